imem_loader: RTL and testbench

//   Writer side of the instruction-memory interface: receives a framed byte stream, assembles
//   big-endian 32-bit words and writes them into instruction memory at consecutive word addresses.
//   The processor fetch path is the reader of the same memory.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_word_packer.sv | 46 ++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_LEN_LO = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_CHK    = 3'd4,
        LDR_DONE   = 3'd5,
        LDR_ERR    = 3'd6
    } ldr_state_e;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs four stream bytes (MSB first) into a 32-bit word; word_valid pulses one cycle later.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_r;
    logic [23:0] shift_r;
    logic [31:0] word_r;
    logic        valid_r;

    assign byte_last  = (cnt_r == 2'd3);
    assign word_valid = valid_r;
    assign word       = word_r;

    // Byte counter, shift register and registered word output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 2'd0;
            shift_r <= 24'd0;
            word_r  <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (clear) begin
                cnt_r   <= 2'd0;
                shift_r <= 24'd0;
            end else if (byte_valid) begin
                cnt_r <= cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    word_r  <= {shift_r, byte_data};
                    valid_r <= 1'b1;
                end else begin
                    shift_r <= {shift_r[15:0], byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU until a good frame lands.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    ldr_state_e        state_r, state_nx_s;
    logic              in_ready_r, cpu_hold_r, load_done_r, load_err_r;
    logic [7:0]        len_hi_r, chk_r;
    logic [15:0]       len_r;
    logic [15:0]       len_full_s;
    logic [ADDR_W:0]   word_idx_r, words_loaded_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic              accept_s, sync_s, data_acc_s, byte_last_s, last_word_s;
    logic              word_valid_s;
    logic [31:0]       word_s;

    assign accept_s    = in_valid & in_ready_r;
    assign sync_s      = accept_s && (state_r == LDR_IDLE) && (in_data == LDR_SYNC_BYTE);
    assign data_acc_s  = accept_s && (state_r == LDR_DATA);
    assign len_full_s  = {len_hi_r, in_data};
    assign last_word_s = ((16'(word_idx_r) + 16'd1) == len_r);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (sync_s),
        .byte_valid (data_acc_s),
        .byte_data  (in_data),
        .byte_last  (byte_last_s),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state logic; every transition except reload needs an accepted byte
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LDR_IDLE: begin
                if (sync_s) state_nx_s = LDR_LEN_HI;
                else        state_nx_s = LDR_IDLE;
            end
            LDR_LEN_HI: begin
                if (accept_s) state_nx_s = LDR_LEN_LO;
                else          state_nx_s = LDR_LEN_HI;
            end
            LDR_LEN_LO: begin
                if (!accept_s)                state_nx_s = LDR_LEN_LO;
                else if (len_full_s > MAX_N)  state_nx_s = LDR_ERR;
                else if (len_full_s == 16'd0) state_nx_s = LDR_CHK;
                else                          state_nx_s = LDR_DATA;
            end
            LDR_DATA: begin
                if (data_acc_s && byte_last_s && last_word_s) state_nx_s = LDR_CHK;
                else                                          state_nx_s = LDR_DATA;
            end
            LDR_CHK: begin
                if (!accept_s)            state_nx_s = LDR_CHK;
                else if (in_data == chk_r) state_nx_s = LDR_DONE;
                else                      state_nx_s = LDR_ERR;
            end
            LDR_DONE, LDR_ERR: begin
                if (reload) state_nx_s = LDR_IDLE;
                else        state_nx_s = state_r;
            end
            default: state_nx_s = LDR_IDLE;
        endcase
    end

    // State register and handshake/hold outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LDR_IDLE;
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s != LDR_DONE) && (state_nx_s != LDR_ERR);
            cpu_hold_r <= (state_nx_s != LDR_DONE);
        end
    end

    // Length capture, checksum, word index and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_r       <= 8'd0;
            len_r          <= 16'd0;
            chk_r          <= 8'd0;
            word_idx_r     <= '0;
            words_loaded_r <= '0;
            imem_addr_r    <= '0;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
        end else if (sync_s) begin
            len_hi_r       <= 8'd0;
            len_r          <= 16'd0;
            chk_r          <= 8'd0;
            word_idx_r     <= '0;
            words_loaded_r <= '0;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
        end else begin
            if (accept_s && (state_r == LDR_LEN_HI)) len_hi_r <= in_data;
            if (accept_s && (state_r == LDR_LEN_LO)) len_r <= len_full_s;
            if (data_acc_s) begin
                chk_r <= chk_update(chk_r, in_data);
                // Address and count land together with the packer's write strobe
                if (byte_last_s) begin
                    imem_addr_r    <= word_idx_r[ADDR_W-1:0];
                    word_idx_r     <= word_idx_r + (ADDR_W+1)'(1);
                    words_loaded_r <= word_idx_r + (ADDR_W+1)'(1);
                end
            end
            if ((state_r == LDR_CHK) && (state_nx_s == LDR_DONE)) load_done_r <= 1'b1;
            if ((state_r != LDR_ERR) && (state_nx_s == LDR_ERR))  load_err_r  <= 1'b1;
        end
    end

    assign in_ready     = in_ready_r;
    assign cpu_hold     = cpu_hold_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;
    assign words_loaded = words_loaded_r;
    assign imem_we      = word_valid_s;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = word_s;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus hand sequences, write scoreboard.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              reload = 1'b0;
    logic              in_ready, imem_we, cpu_hold, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] bytes;
        int           nbytes;
        logic         exp_done;
        logic         exp_err;
        int           exp_words;
    } vec_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[5];
    wr_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   gap_max = 0;

    localparam logic [127:0] FRAME1 = 128'hA5000220_0800058D_090004AD_00000000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [127:0] f, input int i);
        return f[127-8*i -: 8];
    endfunction

    // Write monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = sb_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write actual=%h/%h expected=%h/%h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_expected(input logic [127:0] f, input int nbytes);
        int n;
        wr_t w;
        n = int'({get_byte(f, 1), get_byte(f, 2)});
        if (n <= MAX_WORDS && nbytes >= 4 + 4 * n) begin
            for (int k = 0; k < n; k++) begin
                w.addr = 8'(k);
                w.data = {get_byte(f, 3+4*k), get_byte(f, 4+4*k),
                          get_byte(f, 5+4*k), get_byte(f, 6+4*k)};
                sb_q.push_back(w);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        if (gap_max > 0) begin
            n = $urandom_range(0, gap_max);
            repeat (n) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept byte=%h", b);
        end
    endtask

    task automatic send_frame(input logic [127:0] f, input int nbytes);
        push_expected(f, nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(get_byte(f, i));
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input int w);
        @(negedge clk);
        check({tag, "_done"},  64'(load_done), 64'(d));
        check({tag, "_err"},   64'(load_err), 64'(e));
        check({tag, "_hold"},  64'(cpu_hold), 64'(!d));
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'(w));
        check({tag, "_sbempty"}, 64'(sb_q.size()), 64'd0);
    endtask

    // Reload with a SYNC byte presented in the same cycle; it must not be taken
    task automatic do_reload(input logic d, input logic e, input int w);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reload_ready", 64'(in_ready), 64'd1);
        check("reload_hold",  64'(cpu_hold), 64'd1);
        check("reload_done",  64'(load_done), 64'(d));
        check("reload_err",   64'(load_err), 64'(e));
        check("reload_words", 64'(words_loaded), 64'(w));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{FRAME1, 12, 1'b1, 1'b0, 2};
        vecs[1] = '{128'hA5000220_0800058D_090004AC_00000000, 12, 1'b0, 1'b1, 2};
        vecs[2] = '{128'hA5000000_00000000_00000000_00000000, 4, 1'b1, 1'b0, 0};
        vecs[3] = '{128'hA5010100_00000000_00000000_00000000, 3, 1'b0, 1'b1, 0};
        vecs[4] = '{128'hA50001A5_A5112233_00000000_00000000, 8, 1'b1, 1'b0, 1};

        #12;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_hold",  64'(cpu_hold), 64'd1);
        check("rst_we",    64'(imem_we), 64'd0);
        check("rst_done",  64'(load_done), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            if (v > 0) do_reload(vecs[v-1].exp_done, vecs[v-1].exp_err, vecs[v-1].exp_words);
            send_frame(vecs[v].bytes, vecs[v].nbytes);
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
            @(posedge clk);
            #1;
        end

        // Garbage before SYNC, then frame 1 with random valid gaps
        do_reload(1'b1, 1'b0, 1);
        gap_max = 3;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(FRAME1, 12);
        check_status("gaps", 1'b1, 1'b0, 2);
        gap_max = 0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a frame
        do_reload(1'b1, 1'b0, 2);
        for (int i = 0; i < 6; i++) send_byte(get_byte(FRAME1, i));
        rst_n = 1'b0;
        #2;
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_hold",  64'(cpu_hold), 64'd1);
        check("arst_we",    64'(imem_we), 64'd0);
        check("arst_addr",  64'(imem_addr), 64'd0);
        check("arst_wdata", 64'(imem_wdata), 64'd0);
        check("arst_done",  64'(load_done), 64'd0);
        check("arst_err",   64'(load_err), 64'd0);
        check("arst_words", 64'(words_loaded), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(FRAME1, 12);
        check_status("after_rst", 1'b1, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
